// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio
//  Purpose  : Memory-mapped UART transmitter. CPU stores fill a TX FIFO and
//             bytes leave as serial frames; STATUS reads allow polling.
//  Options  : UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_mmio #(
  parameter int          CLK_HZ     = 12000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_data_out,
  output logic        tx,
  output logic        tx_busy
);

  localparam int c_DIV   = CLK_HZ / BAUD;
  localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_tx;
  logic               r_ovf;
  logic [31:0]        r_rdata;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;

  logic        w_hit;
  logic        w_wr_txdata;
  logic        w_wr_status;
  logic        w_full;
  logic        w_empty;
  logic [c_AW:0] w_count;
  logic        w_push;
  logic        w_pop;
  logic        w_busy;
  logic        w_baud_done;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused;

  // ------------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------------
  assign w_hit       = (dmem_address[31:3] == BASE_ADDR[31:3]);
  assign w_wr_txdata = dmem_wren & w_hit & ~dmem_address[2];
  assign w_wr_status = dmem_wren & w_hit &  dmem_address[2];

  // ------------------------------------------------------------------------
  // FIFO: extra pointer MSB distinguishes full from empty
  // ------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_push  = w_wr_txdata & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= dmem_data_in[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  // Sticky overflow: set by a dropped store, cleared by STATUS write bit 3
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_wr_txdata && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_wr_status && dmem_data_in[3]) begin
      r_ovf <= 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------------
  assign w_busy   = (r_state != S_IDLE) | ~w_empty;
  assign w_status = {20'd0, 8'(w_count), r_ovf, w_empty, w_full, w_busy};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= (w_hit && dmem_address[2]) ? w_status : 32'd0;
    end
  end

  // ------------------------------------------------------------------------
  // Transmit FSM
  // ------------------------------------------------------------------------
  assign w_baud_done = (r_baud_cnt == c_CNT_W'(c_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_baud_cnt <= '0;
          if (w_pop) begin
            r_shift   <= w_head;
            r_parity  <= ^w_head;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              // Next bit is presented from the pre-shift value's bit 1
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx            = r_tx;
  assign tx_busy       = w_busy;
  assign dmem_data_out = r_rdata;

  assign w_unused = ^{funct3, dmem_data_in[31:8], dmem_address[1:0], r_parity};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// Bench for uart_tx_mmio: directed and randomized stores checked against a
// queue-based model of the FIFO and the expected serial frames.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam int          DIV   = 10;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FFE0;
`ifdef UART_TX_PARITY_EN
  localparam int          NSLOT = 11;
`else
  localparam int          NSLOT = 10;
`endif
  localparam int          FRAME = NSLOT * DIV;
  localparam int          MAXC  = 40000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = 32'd0;
  logic [31:0] dmem_data_in = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] dmem_data_out;
  logic        tx;
  logic        tx_busy;

  uart_tx_mmio #(
    .CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .dmem_wren(dmem_wren),
    .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
    .funct3(funct3), .dmem_data_out(dmem_data_out),
    .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line recorder: one sample of tx / tx_busy per clock, taken at negedge
  logic txlog  [MAXC];
  logic bsylog [MAXC];
  int   rec_cnt = 0;
  always @(negedge clk) begin
    if (rec_cnt < MAXC) begin
      txlog[rec_cnt]  <= tx;
      bsylog[rec_cnt] <= tx_busy;
    end
    rec_cnt <= rec_cnt + 1;
  end

  // Reference model
  logic [7:0] mq[$];
  logic [7:0] mline[$];
  bit         m_ovf  = 1'b0;
  bit         m_idle = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic m_edge(input bit push, input logic [7:0] b);
    bit fb;
    bit pn;
    fb = (mq.size() == DEPTH);
    pn = m_idle && (mq.size() > 0);
    if (push) begin
      if (!fb) mq.push_back(b);
      else     m_ovf = 1'b1;
    end
    if (pn) begin
      mline.push_back(mq.pop_front());
      m_idle = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] cnt;
    bit busy;
    cnt  = 8'(mq.size());
    busy = !m_idle || (mq.size() > 0);
    return {20'd0, cnt, m_ovf, mq.size() == 0, mq.size() == DEPTH, busy};
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_wren    = 1'b1;
    dmem_address = a;
    dmem_data_in = d;
    funct3       = 3'($urandom_range(0, 2));
  endtask

  task automatic idle_bus();
    @(negedge clk);
    dmem_wren    = 1'b0;
    dmem_address = 32'd0;
    dmem_data_in = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    dmem_wren    = 1'b0;
    dmem_address = a;
    @(negedge clk);
    v            = dmem_data_out;
    dmem_address = 32'd0;
  endtask

  task automatic wait_rec(input int i);
    while (rec_cnt <= i) @(posedge clk);
  endtask

  task automatic find_start(input int from, input int budget, output int t, output bit found);
    found = 1'b0;
    t     = from;
    while (!found && t < from + budget) begin
      wait_rec(t);
      if (txlog[t] === 1'b0 && (t == 0 || txlog[t-1] === 1'b1)) found = 1'b1;
      else t++;
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input int from, output int t);
    bit   found;
    logic e;
    logic v;
    logic obs;
    find_start(from, 3000, t, found);
    chk($sformatf("start_%02h", b), {31'd0, found}, 32'd1);
    if (found) begin
      for (int s = 0; s < NSLOT; s++) begin
        e   = exp_bit(b, s);
        obs = e;
        for (int c = 0; c < DIV; c++) begin
          wait_rec(t + s*DIV + c);
          v = txlog[t + s*DIV + c];
          if (v !== e) obs = v;
        end
        chk($sformatf("frame_%02h_slot%0d", b, s), {31'd0, obs}, {31'd0, e});
      end
    end
  endtask

  task automatic drain(input int mark);
    int from;
    int t;
    int tprev;
    logic [7:0] b;
    from  = mark;
    tprev = -1;
    while (mline.size() > 0 || mq.size() > 0) begin
      b = (mline.size() > 0) ? mline.pop_front() : mq.pop_front();
      check_frame(b, from, t);
      if (tprev >= 0) chk("start_gap", 32'(t - tprev), 32'(FRAME + 1));
      tprev = t;
      from  = t + FRAME;
    end
    wait_rec(from);
    chk("idle_tx",    {31'd0, txlog[from]},    32'd1);
    chk("busy_last",  {31'd0, bsylog[from-1]}, 32'd1);
    chk("busy_drop",  {31'd0, bsylog[from]},   32'd0);
    m_idle = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] d;
    int   mark;
    int   n;
    int   t;
    bit   found;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",   {31'd0, tx},      32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b1;
    rd(BASE + 4, v);
    chk("rst_status", v, 32'h0000_0004);
    chk("rst_status_model", v, m_status());

    // Single byte 0xA5
    mark = rec_cnt;
    st(BASE, 32'h0000_00A5); m_edge(1'b1, 8'hA5);
    idle_bus();              m_edge(1'b0, 8'h00);
    rd(BASE + 4, v);
    chk("single_status", v, m_status());
    drain(mark);

    // Byte 0x07 via byte offset 1 (low address bits ignored)
    mark = rec_cnt;
    st(BASE + 1, 32'hABCD_EF07); m_edge(1'b1, 8'h07);
    idle_bus();                  m_edge(1'b0, 8'h00);
    drain(mark);

    // Overflow: six back-to-back stores into a 4-deep FIFO
    mark = rec_cnt;
    for (int i = 1; i <= 6; i++) begin
      st(BASE, 32'(i)); m_edge(1'b1, 8'(i));
    end
    idle_bus(); m_edge(1'b0, 8'h00);
    rd(BASE + 4, v);
    chk("ovf_status", v, 32'h0000_004B);
    chk("ovf_status_model", v, m_status());
    rd(BASE, v);
    chk("txdata_read_zero", v, 32'd0);
    drain(mark);
    rd(BASE + 4, v);
    chk("ovf_sticky", v, m_status());
    st(BASE + 4, 32'hFFFF_FFF7); idle_bus();
    rd(BASE + 4, v);
    chk("ovf_keep_bit3_0", v, m_status());
    st(BASE + 4, 32'h0000_0008); idle_bus();
    m_ovf = 1'b0;
    rd(BASE + 4, v);
    chk("ovf_cleared", v, 32'h0000_0004);

    // Randomized bursts, with a non-hit store beforehand
    for (int k = 0; k < 4; k++) begin
      st(BASE ^ (32'd1 << $urandom_range(3, 31)), $urandom);
      idle_bus(); m_edge(1'b0, 8'h00);
      rd(BASE + 4, v);
      chk($sformatf("nonhit_store_%0d", k), v, m_status());
      mark = rec_cnt;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        st(BASE + 32'($urandom_range(0, 3)), d); m_edge(1'b1, d[7:0]);
      end
      idle_bus(); m_edge(1'b0, 8'h00);
      rd(BASE + 4 + 32'($urandom_range(0, 3)), v);
      chk($sformatf("rand_status_%0d", k), v, m_status());
      rd(BASE ^ (32'd1 << $urandom_range(3, 31)), v);
      chk($sformatf("rand_nonhit_read_%0d", k), v, 32'd0);
      drain(mark);
      st(BASE + 4, 32'h0000_0008); idle_bus();
      m_ovf = 1'b0;
    end

    // Reset during data bit 3 of 0x35 (bit 3 = 0)
    mark = rec_cnt;
    st(BASE, 32'h0000_0035); m_edge(1'b1, 8'h35);
    idle_bus();              m_edge(1'b0, 8'h00);
    find_start(mark, 3000, t, found);
    chk("midrst_start", {31'd0, found}, 32'd1);
    wait_rec(t + DIV*4 + 3);
    #2;
    chk("midrst_pre_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_tx",   {31'd0, tx},      32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    mq.delete(); mline.delete(); m_ovf = 1'b0; m_idle = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(BASE + 4, v);
    chk("midrst_status", v, m_status());
    find_start(rec_cnt, 300, t, found);
    chk("midrst_no_frame", {31'd0, found}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
